pipelined_datapath_fwd: RTL



---
 rtl/pipelined_datapath_fwd.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_datapath_fwd.sv
// Four-stage RF -> EX -> MEM -> WB datapath with an internal register file and data memory.
// Provides EX-stage operand forwarding, RF write-through bypass and a load-use stall.
module pipelined_datapath_fwd #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 8
) (
    input  logic              phi1_clk,
    input  logic              main_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_we,
    input  logic [3:0]        in_alu_sel,
    input  logic [MEM_AW-1:0] in_mem_addr,
    input  logic              in_mem_we,
    input  logic              in_wb_sel,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] dbg_alu_z,
    output logic [15:0]       stall_count
);
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int DEPTH    = 2 ** MEM_AW;
    localparam int SH_W     = $clog2(DATA_W);

    logic [DATA_W-1:0] rf_r  [NUM_REGS];
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              idex_valid_r, idex_reg_we_r, idex_mem_we_r, idex_wb_sel_r;
    logic [REG_AW-1:0] idex_rs1_r, idex_rs2_r, idex_rd_r;
    logic [3:0]        idex_alu_sel_r;
    logic [MEM_AW-1:0] idex_mem_addr_r;
    logic [DATA_W-1:0] idex_a_r, idex_b_r;

    logic              exmem_valid_r, exmem_reg_we_r, exmem_mem_we_r, exmem_wb_sel_r;
    logic [REG_AW-1:0] exmem_rd_r;
    logic [MEM_AW-1:0] exmem_mem_addr_r;
    logic [DATA_W-1:0] exmem_alu_r, exmem_store_r;

    logic              wb_valid_r, wb_we_r;
    logic [REG_AW-1:0] wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [15:0]       stall_count_r;

    logic              load_use_s, issue_s;
    logic [DATA_W-1:0] rf_a_s, rf_b_s, fwd_a_s, fwd_b_s, alu_z_s, mem_rdata_s;

    function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] sel,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (sel)
            4'd0:    alu_f = a + b;
            4'd1:    alu_f = a - b;
            4'd2:    alu_f = a & b;
            4'd3:    alu_f = a | b;
            4'd4:    alu_f = a ^ b;
            4'd5:    alu_f = a << sh;
            4'd6:    alu_f = a >> sh;
            4'd7:    alu_f = a;
            4'd8:    alu_f = b;
            4'd9:    alu_f = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : {DATA_W{1'b0}};
            default: alu_f = {DATA_W{1'b0}};
        endcase
    endfunction

    // Load-use hazard against the instruction currently in EX
    always_comb begin
        load_use_s = 1'b0;
        if (in_valid && idex_valid_r && idex_wb_sel_r && idex_reg_we_r && (idex_rd_r != '0) &&
            ((idex_rd_r == in_rs1) || (idex_rd_r == in_rs2))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
        issue_s = in_valid & ~load_use_s;
    end

    // RF read with write-through bypass from the instruction committing this edge
    always_comb begin
        rf_a_s = '0;
        rf_b_s = '0;
        if (in_rs1 == '0) begin
            rf_a_s = '0;
        end else if (wb_valid_r && wb_we_r && (wb_rd_r == in_rs1)) begin
            rf_a_s = wb_data_r;
        end else begin
            rf_a_s = rf_r[in_rs1];
        end
        if (in_rs2 == '0) begin
            rf_b_s = '0;
        end else if (wb_valid_r && wb_we_r && (wb_rd_r == in_rs2)) begin
            rf_b_s = wb_data_r;
        end else begin
            rf_b_s = rf_r[in_rs2];
        end
    end

    // EX operand forwarding: EX/MEM ALU result first, then the WB value
    always_comb begin
        fwd_a_s = idex_a_r;
        fwd_b_s = idex_b_r;
        if ((idex_rs1_r != '0) && exmem_valid_r && exmem_reg_we_r && !exmem_wb_sel_r &&
            (exmem_rd_r == idex_rs1_r)) begin
            fwd_a_s = exmem_alu_r;
        end else if ((idex_rs1_r != '0) && wb_valid_r && wb_we_r && (wb_rd_r == idex_rs1_r)) begin
            fwd_a_s = wb_data_r;
        end else begin
            fwd_a_s = idex_a_r;
        end
        if ((idex_rs2_r != '0) && exmem_valid_r && exmem_reg_we_r && !exmem_wb_sel_r &&
            (exmem_rd_r == idex_rs2_r)) begin
            fwd_b_s = exmem_alu_r;
        end else if ((idex_rs2_r != '0) && wb_valid_r && wb_we_r && (wb_rd_r == idex_rs2_r)) begin
            fwd_b_s = wb_data_r;
        end else begin
            fwd_b_s = idex_b_r;
        end
        alu_z_s     = alu_f(idex_alu_sel_r, fwd_a_s, fwd_b_s);
        mem_rdata_s = mem_r[exmem_mem_addr_r];
    end

    // Register file write from WB; r0 is never written
    always_ff @(posedge phi1_clk or posedge main_rst) begin
        if (main_rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_r[i] <= '0;
        end else if (wb_valid_r && wb_we_r && (wb_rd_r != '0)) begin
            rf_r[wb_rd_r] <= wb_data_r;
        end
    end

    // Data memory store from MEM; the same-edge read already sampled the old word
    always_ff @(posedge phi1_clk or posedge main_rst) begin
        if (main_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (exmem_valid_r && exmem_mem_we_r) begin
            mem_r[exmem_mem_addr_r] <= exmem_store_r;
        end
    end

    // Pipeline stage registers; bubbles carry cleared write enables
    always_ff @(posedge phi1_clk or posedge main_rst) begin
        if (main_rst) begin
            idex_valid_r     <= 1'b0;
            idex_reg_we_r    <= 1'b0;
            idex_mem_we_r    <= 1'b0;
            idex_wb_sel_r    <= 1'b0;
            idex_rs1_r       <= '0;
            idex_rs2_r       <= '0;
            idex_rd_r        <= '0;
            idex_alu_sel_r   <= 4'd0;
            idex_mem_addr_r  <= '0;
            idex_a_r         <= '0;
            idex_b_r         <= '0;
            exmem_valid_r    <= 1'b0;
            exmem_reg_we_r   <= 1'b0;
            exmem_mem_we_r   <= 1'b0;
            exmem_wb_sel_r   <= 1'b0;
            exmem_rd_r       <= '0;
            exmem_mem_addr_r <= '0;
            exmem_alu_r      <= '0;
            exmem_store_r    <= '0;
            wb_valid_r       <= 1'b0;
            wb_we_r          <= 1'b0;
            wb_rd_r          <= '0;
            wb_data_r        <= '0;
        end else begin
            idex_valid_r     <= issue_s;
            idex_reg_we_r    <= issue_s & in_reg_we;
            idex_mem_we_r    <= issue_s & in_mem_we;
            idex_wb_sel_r    <= in_wb_sel;
            idex_rs1_r       <= in_rs1;
            idex_rs2_r       <= in_rs2;
            idex_rd_r        <= in_rd;
            idex_alu_sel_r   <= in_alu_sel;
            idex_mem_addr_r  <= in_mem_addr;
            idex_a_r         <= rf_a_s;
            idex_b_r         <= rf_b_s;
            exmem_valid_r    <= idex_valid_r;
            exmem_reg_we_r   <= idex_reg_we_r;
            exmem_mem_we_r   <= idex_mem_we_r;
            exmem_wb_sel_r   <= idex_wb_sel_r;
            exmem_rd_r       <= idex_rd_r;
            exmem_mem_addr_r <= idex_mem_addr_r;
            exmem_alu_r      <= alu_z_s;
            exmem_store_r    <= fwd_b_s;
            wb_valid_r       <= exmem_valid_r;
            wb_we_r          <= exmem_valid_r & exmem_reg_we_r;
            wb_rd_r          <= exmem_rd_r;
            wb_data_r        <= exmem_wb_sel_r ? mem_rdata_s : exmem_alu_r;
        end
    end

    // Saturating count of cycles refused by the load-use hazard
    always_ff @(posedge phi1_clk or posedge main_rst) begin
        if (main_rst) begin
            stall_count_r <= 16'd0;
        end else if (load_use_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end
    end

    assign in_ready    = ~load_use_s;
    assign wb_valid    = wb_valid_r;
    assign wb_rd       = wb_rd_r;
    assign wb_we       = wb_we_r;
    assign wb_data     = wb_data_r;
    assign dbg_alu_z   = alu_z_s;
    assign stall_count = stall_count_r;
endmodule
